pc_stack: RTL and testbench

- Parametrised next-generation program counter for the CPU fetch stage.
- Adds the following on top of load/increment:
  - configurable address width and step;
  - PC-relative branch;
  - stall;
  - hardware call/return stack of DEPTH entries, with full/empty status and sticky error flags.
- Sits between the control unit (which issues jmp/br/call/ret/inc) and instruction memory (which is driven by o).

---
 rtl/pc_stack.sv | 128 ++++++++++++
 tb/tb_pc_stack.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// ============================================================================
//  Module      : pc_stack
//  Description : Fetch-stage program counter with load/increment, relative
//                branch, stall and a hardware call/return stack.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_stack #(
    parameter int                 WIDTH      = 16,
    parameter int                 DEPTH      = 8,
    parameter logic [WIDTH-1:0]   RESET_ADDR = '0,
    parameter int                 STEP       = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       inc,
    input  logic                       jmp,
    input  logic                       br,
    input  logic                       call,
    input  logic                       ret,
    input  logic [WIDTH-1:0]           d,
    input  logic [WIDTH-1:0]           off,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           o,
    output logic [WIDTH-1:0]           tos,
    output logic [$clog2(DEPTH):0]     sp,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       unf
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              SPW       = AW + 1;
    localparam logic [WIDTH-1:0] c_step   = WIDTH'(STEP);
    localparam logic [SPW-1:0]  c_sp_one  = SPW'(1);
    localparam logic [SPW-1:0]  c_sp_full = SPW'(DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic [SPW-1:0]   r_sp;
    logic [WIDTH-1:0] r_stack [DEPTH];
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH-1:0] w_pc_nxt;
    logic [SPW-1:0]   w_sp_nxt;
    logic [AW-1:0]    w_top_idx;
    logic             w_push;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic             w_full;
    logic             w_empty;

    assign w_full    = (r_sp == c_sp_full);
    assign w_empty   = (r_sp == '0);
    // When full, sp-1 truncated to AW bits still lands on DEPTH-1.
    assign w_top_idx = AW'(r_sp - c_sp_one);

    always_comb begin
        w_pc_nxt  = r_pc;
        w_sp_nxt  = r_sp;
        w_push    = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (!stall) begin
            if (ret) begin
                if (!w_empty) begin
                    w_pc_nxt = r_stack[w_top_idx];
                    w_sp_nxt = r_sp - c_sp_one;
                end else begin
                    w_unf_set = 1'b1;
                end
            end else if (call) begin
                if (!w_full) begin
                    w_push   = 1'b1;
                    w_pc_nxt = d;
                    w_sp_nxt = r_sp + c_sp_one;
                end else begin
                    w_ovf_set = 1'b1;
                end
            end else if (jmp) begin
                w_pc_nxt = d;
            end else if (br) begin
                w_pc_nxt = r_pc + off;
            end else if (inc) begin
                w_pc_nxt = r_pc + c_step;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc  <= RESET_ADDR;
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_sp  <= w_sp_nxt;
            // A new error outranks a simultaneous clear.
            r_ovf <= w_ovf_set | (r_ovf & ~err_clr);
            r_unf <= w_unf_set | (r_unf & ~err_clr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (w_push) begin
            r_stack[r_sp[AW-1:0]] <= r_pc + c_step;
        end
    end

    assign o     = r_pc;
    assign sp    = r_sp;
    assign full  = w_full;
    assign empty = w_empty;
    assign ovf   = r_ovf;
    assign unf   = r_unf;
    assign tos   = w_empty ? '0 : r_stack[w_top_idx];

endmodule

`default_nettype wire

// File: tb/tb_pc_stack.sv
// ============================================================================
//  Module      : tb_pc_stack
//  Description : Self-checking bench for pc_stack against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst, stall, inc, jmp, br, call, ret, err_clr;
    logic [WIDTH-1:0]  d, off;
    logic [WIDTH-1:0]  o, tos;
    logic [3:0]        sp;
    logic              full, empty, ovf, unf;

    pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_ADDR(16'h0000), .STEP(1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .inc(inc), .jmp(jmp), .br(br),
        .call(call), .ret(ret), .d(d), .off(off), .err_clr(err_clr),
        .o(o), .tos(tos), .sp(sp), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // Reference model: PC, return-address queue, sticky flags.
    logic [WIDTH-1:0] m_pc;
    logic [WIDTH-1:0] m_stk [$];
    logic             m_ovf, m_unf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 16'h0000;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_update();
        logic so, su;
        so = 1'b0;
        su = 1'b0;
        if (!stall) begin
            if (ret) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else                  su = 1'b1;
            end else if (call) begin
                if (m_stk.size() < DEPTH) begin
                    m_stk.push_back(m_pc + 16'd1);
                    m_pc = d;
                end else begin
                    so = 1'b1;
                end
            end else if (jmp) m_pc = d;
            else if (br)      m_pc = m_pc + off;
            else if (inc)     m_pc = m_pc + 16'd1;
        end
        m_ovf = so | (m_ovf & ~err_clr);
        m_unf = su | (m_unf & ~err_clr);
    endtask

    // One clock cycle with the given inputs; returns 1 time unit after the edge.
    task automatic step(input logic r, input logic s, input logic i, input logic j,
                        input logic b, input logic c, input logic rt,
                        input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] oo,
                        input logic ec);
        rst = r; stall = s; inc = i; jmp = j; br = b; call = c; ret = rt;
        d = dd; off = oo; err_clr = ec;
        if (!r) model_reset();
        @(posedge clk);
        if (r) model_update();
        #1;
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("o",     32'(o),     32'(m_pc));
            check("tos",   32'(tos),   (m_stk.size() > 0) ? 32'(m_stk[$]) : 32'h0);
            check("sp",    32'(sp),    32'(m_stk.size()));
            check("full",  32'(full),  32'(m_stk.size() == DEPTH));
            check("empty", 32'(empty), 32'(m_stk.size() == 0));
            check("ovf",   32'(ovf),   32'(m_ovf));
            check("unf",   32'(unf),   32'(m_unf));
        end
    end

    initial begin
        rst = 0; stall = 0; inc = 0; jmp = 0; br = 0; call = 0; ret = 0;
        d = '0; off = '0; err_clr = 0;
        model_reset();
        chk_en = 1'b1;

        // Reset and increment/wrap
        repeat (2) step(0, 0, 1, 0, 0, 0, 0, 16'h0, 16'h0, 0);
        check("rst_o", 32'(o), 32'h0);
        check("rst_sp", 32'(sp), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        repeat (3) step(1, 0, 1, 0, 0, 0, 0, 16'h0, 16'h0, 0);
        check("inc3", 32'(o), 32'h3);
        step(1, 0, 0, 1, 0, 0, 0, 16'hFFFF, 16'h0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 16'h0, 16'h0, 0);
        check("inc_wrap", 32'(o), 32'h0);

        // Branch
        step(1, 0, 0, 1, 0, 0, 0, 16'h0010, 16'h0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 16'h0, 16'hFFFC, 0);
        check("br_neg", 32'(o), 32'h000C);
        step(1, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0005, 0);
        check("br_pos", 32'(o), 32'h0011);
        step(1, 0, 0, 1, 1, 0, 0, 16'h0100, 16'h0005, 0);
        check("jmp_over_br", 32'(o), 32'h0100);

        // Nested call/return
        step(1, 0, 0, 1, 0, 0, 0, 16'h0020, 16'h0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 16'h0100, 16'h0, 0);
        check("call1_o", 32'(o), 32'h0100);
        check("call1_sp", 32'(sp), 32'h1);
        check("call1_tos", 32'(tos), 32'h0021);
        step(1, 0, 0, 0, 0, 1, 0, 16'h0200, 16'h0, 0);
        check("call2_sp", 32'(sp), 32'h2);
        check("call2_tos", 32'(tos), 32'h0101);
        step(1, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 0);
        check("ret1_o", 32'(o), 32'h0101);
        step(1, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 0);
        check("ret2_o", 32'(o), 32'h0021);
        check("ret2_empty", 32'(empty), 32'h1);

        // Overflow / underflow
        for (int k = 0; k < DEPTH; k++)
            step(1, 0, 0, 0, 0, 1, 0, 16'h1000 + 16'(k), 16'h0, 0);
        check("full", 32'(full), 32'h1);
        step(1, 0, 0, 0, 0, 1, 0, 16'h0300, 16'h0, 0);
        check("ovf_o", 32'(o), 32'h1007);
        check("ovf_sp", 32'(sp), 32'h8);
        check("ovf_flag", 32'(ovf), 32'h1);
        for (int k = 0; k < DEPTH; k++)
            step(1, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 0);
        check("pop_all_o", 32'(o), 32'h0022);
        check("pop_all_empty", 32'(empty), 32'h1);
        step(1, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 0);
        check("unf_o", 32'(o), 32'h0022);
        check("unf_flag", 32'(unf), 32'h1);
        step(1, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 1);
        check("clr_vs_set_unf", 32'(unf), 32'h1);
        check("clr_ovf", 32'(ovf), 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 1);
        check("clr_unf", 32'(unf), 32'h0);

        // Stall and call+ret priority
        step(1, 0, 0, 0, 0, 1, 0, 16'h0400, 16'h0, 0);
        step(1, 1, 1, 0, 0, 1, 0, 16'h0500, 16'h0, 0);
        check("stall_o", 32'(o), 32'h0400);
        check("stall_sp", 32'(sp), 32'h1);
        check("stall_tos", 32'(tos), 32'h0023);
        step(1, 0, 0, 0, 0, 1, 1, 16'h0600, 16'h0, 0);
        check("callret_o", 32'(o), 32'h0023);
        check("callret_sp", 32'(sp), 32'h0);

        // Async reset mid-operation
        step(1, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 16'h0100, 16'h0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 16'h0150, 16'h0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 16'h0200, 16'h0, 0);
        check("pre_arst_sp", 32'(sp), 32'h3);
        check("pre_arst_o", 32'(o), 32'h0200);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("arst_o", 32'(o), 32'h0);
        check("arst_sp", 32'(sp), 32'h0);
        check("arst_unf", 32'(unf), 32'h0);
        check("arst_tos", 32'(tos), 32'h0);
        step(0, 0, 1, 0, 0, 1, 0, 16'h0, 16'h0, 0);
        idle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic r;
            logic [7:0] sel;
            r   = ($urandom_range(0, 299) != 0);
            sel = 8'($urandom_range(0, 99));
            step(r,
                 ($urandom_range(0, 9) == 0),
                 (sel < 8'd20),
                 (sel >= 8'd20 && sel < 8'd30) || ($urandom_range(0, 7) == 0),
                 (sel >= 8'd30 && sel < 8'd45) || ($urandom_range(0, 7) == 0),
                 (sel >= 8'd45 && sel < 8'd72) || ($urandom_range(0, 9) == 0),
                 (sel >= 8'd72 && sel < 8'd95),
                 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 19) == 0));
        end

        idle();
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
